// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared constants and types for the word-level sequence detector.
//   BYTE_W       : width of one input word
//   DEF_PAT_LEN  : default pattern length in bits
//   DEF_PATTERN  : default pattern, MSB compared against the oldest bit
//   state_e      : controller FSM states
package seq_detect_pkg;

    localparam int BYTE_W = 8;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_bit_detector.sv
// seq_bit_detector
// Bit-serial pattern matcher with a sliding window of the last PAT_LEN bits.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bit_in   : serial data bit
//   bit_en   : bit_in is valid this cycle and is shifted into the window
//   clear    : empty the window history (takes priority over bit_en)
//   match    : combinational; high when the window including bit_in equals
//              PATTERN and the window is completely filled
module seq_bit_detector
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_en,
    input  logic clear,
    output logic match
);

    localparam int                FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] window_r;
    logic [PAT_LEN-1:0] window_nx_s;
    logic [FILL_W-1:0]  fill_r;
    logic [FILL_W-1:0]  fill_nx_s;

    // Next window/fill as if bit_in were shifted in; fill saturates once full.
    always_comb begin
        window_nx_s = {window_r[PAT_LEN-2:0], bit_in};
        if (fill_r == FILL_MAX) begin
            fill_nx_s = fill_r;
        end else begin
            fill_nx_s = fill_r + FILL_W'(1);
        end
    end

    // The match looks at the window that already contains the current bit,
    // so a detection is reported in the same cycle the bit is presented.
    assign match = bit_en && (fill_nx_s == FILL_MAX) && (window_nx_s == PATTERN);

    // Window history register: cleared by reset or clear, advanced by bit_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_r <= '0;
            fill_r   <= '0;
        end else if (clear) begin
            window_r <= '0;
            fill_r   <= '0;
        end else if (bit_en) begin
            window_r <= window_nx_s;
            fill_r   <= fill_nx_s;
        end else begin
            window_r <= window_r;
            fill_r   <= fill_r;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Accepts bytes on a valid/ready handshake, shifts each one MSB-first through
// seq_bit_detector and returns the per-word match count on a valid/ready
// output handshake. Detector history carries across words unless flushed.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_data/valid/ready  : byte input handshake (ready only in IDLE)
//   flush                : clear detector history, honoured only in IDLE
//   out_count/valid/ready: per-word match count handshake
//   hit                  : one-cycle pulse in the cycle after a matching bit
//   total_hits           : saturating count of all detections since reset
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W   = 4,
    parameter int                 TOT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              hit,
    output logic [TOT_W-1:0]  total_hits
);

    localparam logic [1:0]       IDLE    = ST_IDLE;
    localparam logic [1:0]       SHIFT   = ST_SHIFT;
    localparam logic [1:0]       DONE    = ST_DONE;
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

    logic [1:0]        state_r;
    logic [BYTE_W-1:0] shreg_r;
    logic [2:0]        bit_cnt_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic              match_s;
    logic              bit_en_s;
    logic              clear_s;

    assign bit_en_s = (state_r == SHIFT);
    assign clear_s  = (state_r == IDLE) && flush;

    seq_bit_detector #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk    (clk),
        .rst    (rst),
        .bit_in (shreg_r[BYTE_W-1]),
        .bit_en (bit_en_s),
        .clear  (clear_s),
        .match  (match_s)
    );

    // Controller FSM, shift register, counters and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            bit_cnt_r  <= 3'd0;
            word_cnt_r <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_count  <= '0;
            hit        <= 1'b0;
            total_hits <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    hit <= 1'b0;
                    if (in_valid && in_ready) begin
                        shreg_r    <= in_data;
                        bit_cnt_r  <= 3'd0;
                        word_cnt_r <= '0;
                        in_ready   <= 1'b0;
                        state_r    <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg_r   <= {shreg_r[BYTE_W-2:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    hit       <= match_s;
                    if (match_s) begin
                        word_cnt_r <= word_cnt_r + CNT_W'(1);
                        if (total_hits != TOT_MAX) begin
                            total_hits <= total_hits + TOT_W'(1);
                        end else begin
                            total_hits <= total_hits;
                        end
                    end else begin
                        word_cnt_r <= word_cnt_r;
                    end
                    // Last bit: fold its own match into the presented count.
                    if (bit_cnt_r == 3'd7) begin
                        out_count <= word_cnt_r + (match_s ? CNT_W'(1) : CNT_W'(0));
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    hit <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    hit       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl
// Self-checking bench: directed scenarios plus randomized words, checked
// against a bit-history queue model of the pattern rules.
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // main instance: default pattern 1011, 16-bit total
    logic [7:0]  in_data;
    logic        in_valid, in_ready, flush;
    logic [3:0]  out_count;
    logic        out_valid, out_ready, hit;
    logic [15:0] total_hits;

    // saturation instance: pattern 1111, 4-bit total
    logic [7:0]  s_in_data;
    logic        s_in_valid, s_in_ready, s_flush;
    logic [3:0]  s_out_count;
    logic        s_out_valid, s_out_ready, s_hit;
    logic [3:0]  s_total_hits;

    seq_detect_ctrl dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready), .hit(hit),
        .total_hits(total_hits)
    );

    seq_detect_ctrl #(.PATTERN(4'b1111), .TOT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .flush(s_flush), .out_count(s_out_count),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .hit(s_hit),
        .total_hits(s_total_hits)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the bits seen since the last reset/flush (only the
    // newest four matter), and the saturating totals.
    bit hist_q[$];
    bit shist_q[$];
    int m_total;
    int s_total;

    function automatic bit push_main(input bit b);
        hist_q.push_back(b);
        if (hist_q.size() > 4) void'(hist_q.pop_front());
        return (hist_q.size() == 4) && hist_q[0] && !hist_q[1] && hist_q[2] && hist_q[3];
    endfunction

    function automatic bit push_sat(input bit b);
        shist_q.push_back(b);
        if (shist_q.size() > 4) void'(shist_q.pop_front());
        return (shist_q.size() == 4) && shist_q[0] && shist_q[1] && shist_q[2] && shist_q[3];
    endfunction

    // One complete word on the main instance: fl flushes on the accept edge,
    // bp cycles of backpressure in DONE, want >= 0 is a fixed expected count.
    task automatic run_word(input logic [7:0] b, input bit fl, input int bp, input int want);
        int exp_cnt;
        bit m;
        @(negedge clk);
        check_eq("idle_rdy", in_ready, 1);
        check_eq("idle_ov", out_valid, 0);
        in_data = b; in_valid = 1'b1; flush = fl; out_ready = 1'($urandom);
        @(posedge clk);
        if (fl) hist_q.delete();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check_eq("acc_rdy", in_ready, 0);
        check_eq("acc_hit", hit, 0);
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            // these must all be ignored while shifting
            in_valid = 1'($urandom); in_data = 8'($urandom);
            flush = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk);
            m = push_main(b[7-i]);
            if (m) begin
                exp_cnt++;
                if (m_total < 65535) m_total++;
            end
            @(negedge clk);
            check_eq($sformatf("hit_bit%0d", i), hit, m);
            if (i < 7) check_eq("shift_ov", out_valid, 0);
        end
        check_eq("done_ov", out_valid, 1);
        check_eq("done_cnt", out_count, exp_cnt);
        check_eq("done_tot", total_hits, m_total);
        if (want >= 0) check_eq("plan_cnt", out_count, want);
        for (int c = 0; c < bp; c++) begin
            out_ready = 1'b0; in_valid = 1'($urandom);
            in_data = 8'($urandom); flush = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_ov", out_valid, 1);
            check_eq("bp_cnt", out_count, exp_cnt);
            check_eq("bp_rdy", in_ready, 0);
            check_eq("bp_hit", hit, 0);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("rel_ov", out_valid, 0);
        check_eq("rel_rdy", in_ready, 1);
        check_eq("rel_tot", total_hits, m_total);
    endtask

    task automatic flush_idle();
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        hist_q.delete();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic sat_word(input logic [7:0] b, input int want_cnt, input int want_tot);
        int exp_cnt;
        @(negedge clk);
        s_in_data = b; s_in_valid = 1'b1; s_flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (push_sat(b[7-i])) begin
                exp_cnt++;
                if (s_total < 15) s_total++;
            end
        end
        @(negedge clk);
        check_eq("sat_ov", s_out_valid, 1);
        check_eq("sat_cnt", s_out_count, exp_cnt);
        check_eq("sat_tot", s_total_hits, s_total);
        check_eq("sat_plan_cnt", s_out_count, want_cnt);
        check_eq("sat_plan_tot", s_total_hits, want_tot);
        s_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_data = 8'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        s_in_data = 8'd0; s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0;
        m_total = 0; s_total = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy", in_ready, 1);
        check_eq("rst_ov", out_valid, 0);
        check_eq("rst_cnt", out_count, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_tot", total_hits, 0);
        check_eq("rst_sat_tot", s_total_hits, 0);
        rst = 1'b0;

        flush_idle();
        run_word(8'h2D, 1'b0, 0, 1);
        run_word(8'h5B, 1'b1, 0, 2);
        // boundary carry, then the same with a flush between the words
        run_word(8'h05, 1'b1, 0, 0);
        run_word(8'h80, 1'b0, 0, 1);
        run_word(8'h05, 1'b1, 0, 0);
        flush_idle();
        run_word(8'h80, 1'b0, 0, 0);
        // long backpressure
        run_word(8'h2D, 1'b1, 20, 1);

        // reset in the middle of a word
        @(negedge clk);
        in_data = 8'hB0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rdy", in_ready, 1);
        check_eq("mid_rst_ov", out_valid, 0);
        check_eq("mid_rst_tot", total_hits, 0);
        check_eq("mid_rst_hit", hit, 0);
        hist_q.delete();
        m_total = 0;
        @(negedge clk);
        rst = 1'b0;
        run_word(8'hB0, 1'b1, 0, 1);

        // randomized words
        for (int k = 0; k < 30; k++) begin
            if (($urandom % 6) == 0) flush_idle();
            run_word(8'($urandom), (($urandom % 4) == 0), int'($urandom % 4), -1);
        end

        // saturation of a narrow total
        sat_word(8'hFF, 5, 5);
        sat_word(8'hFF, 8, 13);
        sat_word(8'hFF, 8, 15);
        sat_word(8'hFF, 8, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
